// File: rtl/circle_run_ctrl.sv
// circle_run_ctrl
//
// Purpose:
//   Drives a circular "running light" pattern position.
//   - A free-running prescaler produces two step rates.
//   - In direction 0 (up, slow rate) the position advances each step.
//   - In direction 1 (down, fast rate) it retreats each step.
//   - After LAPS completed laps the direction flips and the lap count restarts.
//   - The lap count is shown on an active-low 7-segment digit.
//   - The decimal point marks the fast/down direction.
//
// Ports:
//   clk           in   system clock, rising edge
//   rst           in   asynchronous reset, active low
//   pause         in   synchronous; high drops step ticks (prescaler keeps running)
//   ptn_idx       out  current pattern position 0..STEPS-1
//   dir           out  0 = up/slow, 1 = down/fast
//   lap           out  completed laps in the current direction 0..LAPS-1
//   step_tick     out  one-cycle pulse on each accepted step
//   seg7_lap      out  active-low segments {g,f,e,d,c,b,a} of the lap digit
//   seg7_lap_dpt  out  active-low decimal point, lit when dir = 1
module circle_run_ctrl #(
    parameter int DIV_SLOW = 24,
    parameter int DIV_FAST = 23,
    parameter int STEPS    = 10,
    parameter int LAPS     = 3,
    parameter int PTN_W    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pause,
    output logic [PTN_W-1:0] ptn_idx,
    output logic             dir,
    output logic [3:0]       lap,
    output logic             step_tick,
    output logic [6:0]       seg7_lap,
    output logic             seg7_lap_dpt
);

    localparam logic [PTN_W-1:0] PTN_LAST = PTN_W'(STEPS - 1);
    localparam logic [PTN_W-1:0] PTN_ONE  = PTN_W'(1);
    localparam logic [3:0]       LAP_LAST = 4'(LAPS - 1);

    logic [DIV_SLOW-1:0] presc_q;
    logic [DIV_SLOW-1:0] presc_d;
    logic [PTN_W-1:0]    ptn_q;
    logic [PTN_W-1:0]    ptn_d;
    logic [3:0]          lap_q;
    logic [3:0]          lap_d;
    logic                dir_q;
    logic                dir_d;

    logic tick_slow;
    logic tick_fast;
    logic step_en;
    logic lap_done;

    // The fast tick looks only at the low prescaler bits. The prescaler is
    // never cleared on a direction change, so both rates stay phase-locked
    // to the same free-running count.
    assign tick_slow = &presc_q;
    assign tick_fast = &presc_q[DIV_FAST-1:0];

    // Single clock; stepping is a clock enable. A tick during pause is lost.
    // In reset the prescaler is zero, so both ticks are low.
    assign step_en = (dir_q ? tick_fast : tick_slow) & ~pause;

    // A lap ends only on the step that lands on position 0.
    // The 0 -> STEPS-1 wrap when counting down is not a lap end.
    assign lap_done = dir_q ? (ptn_q == PTN_ONE) : (ptn_q == PTN_LAST);

    always_comb begin
        presc_d = presc_q + DIV_SLOW'(1);
        ptn_d   = ptn_q;
        lap_d   = lap_q;
        dir_d   = dir_q;
        if (step_en) begin
            if (!dir_q) begin
                ptn_d = (ptn_q == PTN_LAST) ? '0 : ptn_q + PTN_ONE;
            end else begin
                ptn_d = (ptn_q == '0) ? PTN_LAST : ptn_q - PTN_ONE;
            end
            if (lap_done) begin
                if (lap_q == LAP_LAST) begin
                    lap_d = '0;
                    dir_d = ~dir_q;
                end else begin
                    lap_d = lap_q + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc_q <= '0;
            ptn_q   <= '0;
            lap_q   <= '0;
            dir_q   <= 1'b0;
        end else begin
            presc_q <= presc_d;
            ptn_q   <= ptn_d;
            lap_q   <= lap_d;
            dir_q   <= dir_d;
        end
    end

    // Lap digit decode, active low {g,f,e,d,c,b,a}. Values above 9 are blank.
    always_comb begin
        case (lap_q)
            4'd0:    seg7_lap = 7'b1000000;
            4'd1:    seg7_lap = 7'b1111001;
            4'd2:    seg7_lap = 7'b0100100;
            4'd3:    seg7_lap = 7'b0110000;
            4'd4:    seg7_lap = 7'b0011001;
            4'd5:    seg7_lap = 7'b0010010;
            4'd6:    seg7_lap = 7'b0000010;
            4'd7:    seg7_lap = 7'b1111000;
            4'd8:    seg7_lap = 7'b0000000;
            4'd9:    seg7_lap = 7'b0010000;
            default: seg7_lap = 7'b1111111;
        endcase
    end

    assign seg7_lap_dpt = ~dir_q;
    assign ptn_idx      = ptn_q;
    assign lap          = lap_q;
    assign dir          = dir_q;
    assign step_tick    = step_en;

endmodule

// File: tb/tb_circle_run_ctrl.sv
module tb_circle_run_ctrl;

    logic       clk;
    logic       rst;
    logic       pause;
    logic [1:0] ptn_idx;
    logic       dir;
    logic [3:0] lap;
    logic       step_tick;
    logic [6:0] seg7_lap;
    logic       seg7_lap_dpt;

    int checks_cnt = 0;
    int errors_cnt = 0;

    circle_run_ctrl #(
        .DIV_SLOW (3),
        .DIV_FAST (2),
        .STEPS    (4),
        .LAPS     (2),
        .PTN_W    (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pause        (pause),
        .ptn_idx      (ptn_idx),
        .dir          (dir),
        .lap          (lap),
        .step_tick    (step_tick),
        .seg7_lap     (seg7_lap),
        .seg7_lap_dpt (seg7_lap_dpt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected segments for a lap digit, used only for laps 0 and 1.
    function automatic logic [6:0] seg_of(input int l);
        return (l == 1) ? 7'b1111001 : 7'b1000000;
    endfunction

    task automatic check_reset_outs(input string tag);
        check({tag, "_ptn"},  32'(ptn_idx),      0);
        check({tag, "_lap"},  32'(lap),          0);
        check({tag, "_dir"},  32'(dir),          0);
        check({tag, "_tick"}, 32'(step_tick),    0);
        check({tag, "_seg"},  32'(seg7_lap),     32'(7'b1000000));
        check({tag, "_dpt"},  32'(seg7_lap_dpt), 1);
    endtask

    // Starting at a negedge sample point, wait for step_tick (bounded),
    // check the wait length, then check the registered state one cycle later.
    task automatic do_step(input int n, input int exp_wait, input int e_ptn,
                           input int e_lap, input int e_dir);
        int cnt;
        cnt = 0;
        while (cnt < 64) begin
            @(negedge clk);
            cnt++;
            if (step_tick) break;
        end
        check($sformatf("step%0d_wait", n), 32'(cnt), 32'(exp_wait));
        @(negedge clk);
        check($sformatf("step%0d_ptn", n),  32'(ptn_idx),      32'(e_ptn));
        check($sformatf("step%0d_lap", n),  32'(lap),          32'(e_lap));
        check($sformatf("step%0d_dir", n),  32'(dir),          32'(e_dir));
        check($sformatf("step%0d_pulse", n), 32'(step_tick),   0);
        check($sformatf("step%0d_seg", n),  32'(seg7_lap),     32'(seg_of(e_lap)));
        check($sformatf("step%0d_dpt", n),  32'(seg7_lap_dpt), 32'(e_dir == 0));
        $display("step %0d: wait=%0d ptn=%0d lap=%0d dir=%0d seg=%b dpt=%b",
                 n, cnt, ptn_idx, lap, dir, seg7_lap, seg7_lap_dpt);
    endtask

    // Ticks 1..16 form one full up/down cycle; 17..28 continue into the next one.
    int t_ptn [28] = '{1,2,3,0, 1,2,3,0, 3,2,1,0, 3,2,1,0,
                       1,2,3,0, 1,2,3,0, 3,2,1,0};
    int t_lap [28] = '{0,0,0,1, 1,1,1,0, 0,0,0,1, 1,1,1,0,
                       0,0,0,1, 1,1,1,0, 0,0,0,1};
    int t_dir [28] = '{0,0,0,0, 0,0,0,1, 1,1,1,1, 1,1,1,0,
                       0,0,0,0, 0,0,0,1, 1,1,1,1};
    int t_wait[28] = '{7,7,7,7, 7,7,7,7, 3,3,3,3, 3,3,3,3,
                       7,7,7,7, 7,7,7,7, 3,3,3,3};

    initial begin
        rst   = 1'b0;
        pause = 1'b0;

        // Reset held
        repeat (3) @(negedge clk);
        check_reset_outs("rst_hold");
        $display("reset: ptn=%0d lap=%0d dir=%0d seg=%b dpt=%b",
                 ptn_idx, lap, dir, seg7_lap, seg7_lap_dpt);

        // Release between edges; prescaler starts from 0
        rst = 1'b1;
        for (int i = 0; i < 17; i++) begin
            do_step(i + 1, t_wait[i], t_ptn[i], t_lap[i], t_dir[i]);
        end

        // Pause mid-lap (ptn=1, prescaler=0): two ticks fall inside and are dropped
        pause = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check($sformatf("pause%0d_tick", i), 32'(step_tick), 0);
        end
        check("pause_ptn", 32'(ptn_idx), 1);
        check("pause_lap", 32'(lap),     0);
        check("pause_dir", 32'(dir),     0);
        $display("pause: 20 cycles held, ptn=%0d lap=%0d dir=%0d", ptn_idx, lap, dir);
        pause = 1'b0;
        // Prescaler is now 4, so the next tick is 3 cycles out and advances by one only
        do_step(18, 3, 2, 0, 0);
        for (int i = 18; i < 28; i++) begin
            do_step(i + 1, t_wait[i], t_ptn[i], t_lap[i], t_dir[i]);
        end

        // Now dir=1, lap=1: asynchronous reset between edges
        #2;
        rst = 1'b0;
        #1;
        check_reset_outs("async_rst");
        $display("async reset: ptn=%0d lap=%0d dir=%0d seg=%b dpt=%b",
                 ptn_idx, lap, dir, seg7_lap, seg7_lap_dpt);
        @(negedge clk);
        check_reset_outs("async_rst_hold");
        rst = 1'b1;
        // First slow tick after release comes when the prescaler reaches 7
        do_step(29, 7, 1, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/circle_run_ctrl.md
CIRCLE_RUN_CTRL -- requirements
Module: circle_run_ctrl

Interface
REQ-001 SHALL have parameter DIV_SLOW, default 24, meaning slow step period is 2^DIV_SLOW clk cycles.
REQ-002 SHALL have parameter DIV_FAST, default 23, meaning fast step period is 2^DIV_FAST clk cycles; legal range 1 <= DIV_FAST < DIV_SLOW.
REQ-003 SHALL have parameter STEPS, default 10, meaning the number of pattern positions per lap; legal range 2..2^PTN_W.
REQ-004 SHALL have parameter LAPS, default 3, meaning the number of laps per direction; legal range 1..10.
REQ-005 SHALL have parameter PTN_W, default 4, meaning the ptn_idx width.
REQ-006 clk  input  1  single system clock; all state updates on the rising edge.
REQ-007 rst  input  1  reset, asynchronous, active-low.
REQ-008 pause  input  1  synchronous; high suppresses stepping.
REQ-009 ptn_idx  output  PTN_W  current pattern position, range 0..STEPS-1.
REQ-010 dir  output  1  0 = up/clockwise/slow, 1 = down/counter-clockwise/fast.
REQ-011 lap  output  4  completed laps in the current direction, range 0..LAPS-1.
REQ-012 step_tick  output  1  one-cycle pulse on each accepted step.
REQ-013 seg7_lap  output  7  active-low segments {g,f,e,d,c,b,a}, showing the lap digit.
REQ-014 seg7_lap_dpt  output  1  active-low decimal point; lit (0) when dir=1.

Function
REQ-015 SHALL contain a free-running DIV_SLOW-bit prescaler that increments every cycle, wraps to 0, and ignores pause.
REQ-016 tick_slow SHALL be high in a cycle when the prescaler equals all ones.
REQ-017 tick_fast SHALL be high in a cycle when the low DIV_FAST prescaler bits equal all ones.
REQ-018 step_tick SHALL equal (dir ? tick_fast : tick_slow) & ~pause; a tick that coincides with pause is dropped, not deferred.
REQ-019 Stepping SHALL use clock enables only; there are no derived or gated clocks.
REQ-020 On step_tick with dir=0, ptn_idx SHALL increment; STEPS-1 wraps to 0.
REQ-021 On step_tick with dir=1, ptn_idx SHALL decrement; 0 wraps to STEPS-1.
REQ-022 A lap completes only on the step that lands on 0: STEPS-1->0 when up, 1->0 when down. The 0->STEPS-1 step is not a lap event.
REQ-023 On lap completion with lap < LAPS-1, lap SHALL increment.
REQ-024 On lap completion with lap == LAPS-1, the block SHALL in the same edge set lap to 0 and toggle dir.
REQ-025 With LAPS=1, dir SHALL toggle on every lap completion.
REQ-026 ptn_idx, lap and dir SHALL be registered and take their new values on the edge where step_tick=1, visible the following cycle.
REQ-027 seg7_lap and seg7_lap_dpt SHALL be combinational decodes of the lap and dir registers.
REQ-028 seg7_lap decode SHALL be: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000; values above 9 give 1111111 (blank).
REQ-029 Direction changes SHALL NOT reset the prescaler, so the first fast step follows 2^DIV_FAST cycles after the switching tick.

Reset
REQ-030 rst=0 SHALL immediately and asynchronously force prescaler=0, ptn_idx=0, lap=0, dir=0 and step_tick=0.
REQ-031 During reset, seg7_lap SHALL be 1000000 and seg7_lap_dpt SHALL be 1.
REQ-032 Reset asserted at any point, including the cycle of a step_tick or direction switch, SHALL win; no partial update survives.
REQ-033 After rst deasserts, the first slow tick SHALL occur in the cycle where the prescaler reaches 2^DIV_SLOW-1.

Verification (DIV_SLOW=3, DIV_FAST=2, STEPS=4, LAPS=2)
REQ-034 Reset check: hold rst=0 -> ptn_idx=0, lap=0, dir=0, step_tick=0, seg7_lap=1000000, seg7_lap_dpt=1.
REQ-035 Up stepping: release rst -> step_tick every 8th cycle; ptn_idx goes 1,2,3,0; on the 4th tick lap=1 and seg7_lap=1111001.
REQ-036 Direction switch: 8th tick -> ptn_idx=0, lap=0, dir=1, seg7_lap_dpt=0; then step_tick every 4th cycle; ptn_idx goes 3,2,1,0; lap=1 on the 1->0 step.
REQ-037 Full cycle: after 16 ticks -> dir=0, lap=0, ptn_idx=0, and the slow period of 8 cycles resumes.
REQ-038 Pause: assert pause for 20 cycles mid-lap -> step_tick stays 0 and all state is frozen; after release, the next tick falls on the prescaler schedule and no missed tick is replayed.
REQ-039 Async reset mid-operation: pulse rst=0 between edges while dir=1, lap=1 -> outputs return to reset values before the next clk edge.
